// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider for the EX stage: restoring radix-2, one quotient bit per
// cycle. Produces {hi = remainder, lo = quotient} and stalls the front of the pipe while busy.
module div_unit #(
  parameter logic [4:0] AluSignedDiv   = 5'b11010,
  parameter logic [4:0] AluUnsignedDiv = 5'b11011
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  alu_controlE,
  input  logic [31:0] src_aE,
  input  logic [31:0] src_bE,
  input  logic        flushE,
  input  logic        ex_advanceE,
  output logic        div_stallE,
  output logic        div_readyE,
  output logic [63:0] div_resultE
);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;

  logic        is_div;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] trial;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    is_div = (alu_controlE == AluSignedDiv) || (alu_controlE == AluUnsignedDiv);
    a_neg  = (alu_controlE == AluSignedDiv) && src_aE[31];
    b_neg  = (alu_controlE == AluSignedDiv) && src_bE[31];
    a_mag  = a_neg ? -src_aE : src_aE;
    b_mag  = b_neg ? -src_bE : src_bE;

    // Shift in the next dividend bit and try subtracting; a borrow means restore.
    trial   = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    rem_nx  = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
    quo_nx  = {quo_q[30:0], ~trial[32]};
    quo_fix = qneg_q ? -quo_nx : quo_nx;
    rem_fix = rneg_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (is_div && !flushE) begin
          quo_d  = a_mag;
          rem_d  = '0;
          dvs_d  = b_mag;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (src_bE == 32'd0) begin
            result_d = {src_aE, 32'hFFFF_FFFF};
            state_d  = StDone;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        if (flushE) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
          if (cnt_q == 6'd31) begin
            result_d = {rem_fix, quo_fix};
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      StDone: begin
        if (flushE || ex_advanceE) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // Reset gating keeps the stall low while the pipe is held in reset.
  always_comb begin
    div_stallE  = resetn && !flushE &&
                  (((state_q == StIdle) && is_div) || (state_q == StDiv));
    div_readyE  = (state_q == StDone) && !flushE;
    div_resultE = result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {hi,lo} and ready cycle; a negedge
// monitor pops and compares on each new div_readyE.
module tb_div_unit;

  localparam logic [4:0] SDIV = 5'b11010;
  localparam logic [4:0] UDIV = 5'b11011;
  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] ADD  = 5'b00001;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  alu_controlE = SDIV;
  logic [31:0] src_aE = 32'd0;
  logic [31:0] src_bE = 32'd0;
  logic        flushE = 1'b0;
  logic        ex_advanceE = 1'b1;
  logic        div_stallE;
  logic        div_readyE;
  logic [63:0] div_resultE;

  div_unit #(
    .AluSignedDiv  (SDIV),
    .AluUnsignedDiv(UDIV)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .alu_controlE(alu_controlE),
    .src_aE      (src_aE),
    .src_bE      (src_bE),
    .flushE      (flushE),
    .ex_advanceE (ex_advanceE),
    .div_stallE  (div_stallE),
    .div_readyE  (div_readyE),
    .div_resultE (div_resultE)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (div_readyE && !prev_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", div_resultE, e.res);
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_ready = div_readyE;
  end

  task automatic start(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int lat, input bit push);
    @(posedge clk);
    #1;
    alu_controlE = code;
    src_aE = a;
    src_bE = b;
    if (push) sb.push_back('{res: exp_res, cyc: cyc + 32'(lat)});
    #1 check("stall_on_issue", 64'(div_stallE), 64'd1);
    @(posedge clk);
    #1;
    alu_controlE = NOP;
    src_aE = $urandom;
    src_bE = $urandom;
  endtask

  task automatic wait_ready(input string name);
    bit seen = 1'b0;
    bit stall_bad = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (div_readyE) seen = 1'b1;
      else if (!div_stallE) stall_bad = 1'b1;
    end
    check({name, "_ready"}, 64'(seen), 64'd1);
    check({name, "_stall_busy"}, 64'(stall_bad), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with a divide code present.
    #12;
    check("rst_stall", 64'(div_stallE), 64'd0);
    check("rst_ready", 64'(div_readyE), 64'd0);
    check("rst_result", div_resultE, 64'd0);
    @(posedge clk);
    #1;
    alu_controlE = NOP;
    resetn = 1'b1;

    start(UDIV, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1);
    wait_ready("u100_7");
    start(SDIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1);
    wait_ready("s_m7_2");
    start(SDIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 1);
    wait_ready("s_7_m2");
    start(SDIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1);
    wait_ready("s_min_m1");
    start(UDIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1, 1);
    wait_ready("u5_0");
    // Unsigned must not treat bit 31 as a sign.
    start(UDIV, 32'hFFFF_FFFF, 32'd10, {32'd5, 32'h1999_9999}, 33, 1);
    wait_ready("u_max_10");

    // Non-divide op leaves the unit idle.
    @(posedge clk);
    #1;
    alu_controlE = ADD;
    #1 check("nondiv_stall", 64'(div_stallE), 64'd0);
    repeat (3) @(negedge clk);
    check("nondiv_ready", 64'(div_readyE), 64'd0);
    alu_controlE = NOP;

    // External stall in DONE with a divide code present: hold, no restart.
    ex_advanceE = 1'b0;
    start(UDIV, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 1);
    wait_ready("u1000_10");
    alu_controlE = UDIV;
    src_aE = 32'd77;
    src_bE = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(div_readyE), 64'd1);
      check("hold_result", div_resultE, {32'd0, 32'd100});
    end
    @(posedge clk);
    #1;
    alu_controlE = NOP;
    ex_advanceE = 1'b1;
    @(negedge clk);
    check("adv_still_done", 64'(div_readyE), 64'd1);
    @(negedge clk);
    check("adv_idle_ready", 64'(div_readyE), 64'd0);
    check("adv_idle_stall", 64'(div_stallE), 64'd0);

    // Flush at iteration 10: no result ever, then a fresh divide.
    start(UDIV, 32'd1000, 32'd3, 64'd0, 33, 0);
    repeat (10) @(posedge clk);
    #1;
    flushE = 1'b1;
    #1 check("flush_stall_comb", 64'(div_stallE), 64'd0);
    @(posedge clk);
    #1;
    flushE = 1'b0;
    check("flush_idle_stall", 64'(div_stallE), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_no_ready", 64'(div_readyE), 64'd0);
    start(UDIV, 32'd50, 32'd6, {32'd2, 32'd8}, 33, 1);
    wait_ready("u50_6");

    // Reset at iteration 20 with a divide code on the bus.
    start(SDIV, 32'hFFFF_FF9C, 32'd7, 64'd0, 33, 0);
    repeat (20) @(posedge clk);
    #1;
    alu_controlE = UDIV;
    resetn = 1'b0;
    #1;
    check("mid_rst_ready", 64'(div_readyE), 64'd0);
    check("mid_rst_result", div_resultE, 64'd0);
    check("mid_rst_stall", 64'(div_stallE), 64'd0);
    @(posedge clk);
    #1;
    alu_controlE = NOP;
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_no_ready", 64'(div_readyE), 64'd0);
    start(UDIV, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1);
    wait_ready("u9_3");

    // Back-to-back: the second issue lands in the single IDLE cycle after DONE.
    start(SDIV, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 1);
    wait_ready("s_m100_7");
    start(UDIV, 32'd12345, 32'd100, {32'd45, 32'd123}, 33, 1);
    wait_ready("u12345_100");

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
